// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the data-memory responder slice.
package mem_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // An address is backed by storage only when no bit above the index is set.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input int unsigned depth_log2);
    return (depth_log2 >= ADDR_W) || ((32'(addr) >> depth_log2) == 32'd0);
  endfunction

endpackage

// File: rtl/mem_resp_if.sv
// Request/response handshake between the CPU data port and the responder.
interface mem_resp_if;
  import mem_pkg::*;

  logic              req_vld;
  logic              req_rdy;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_vld;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_vld, req_we, req_addr, req_wdata,
    input  req_rdy, resp_vld, resp_rdata, resp_err
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata,
    output req_rdy, resp_vld, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Word-addressed backing store: synchronous write, combinational read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wdata;
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_resp.sv
// Fixed-latency memory responder: accepts one request, waits LATENCY cycles,
// performs the access and returns a single-cycle response.
module mem_resp
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_resp_if.slave    bus,
  output logic         busy
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] arr_rdata;
  logic              in_range;
  logic              commit;
  logic              arr_we;

  assign in_range = addr_in_range(lat_addr, DEPTH_LOG2);
  assign commit   = (state_q == S_WAIT) && (cnt_q == '0);
  // Writes land only on the WAIT->RESP edge, so a reset before then leaves the array untouched.
  assign arr_we   = commit && lat_we && in_range;

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .idx   (lat_addr[DEPTH_LOG2-1:0]),
    .wdata (lat_wdata),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (bus.req_vld) state_d = S_WAIT;
      S_WAIT: if (cnt_q == '0) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_vld) begin
            lat_we    <= bus.req_we;
            lat_addr  <= bus.req_addr;
            lat_wdata <= bus.req_wdata;
            cnt_q     <= CNT_W'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            rdata_q <= (!lat_we && in_range) ? arr_rdata : '0;
            err_q   <= !in_range;
          end
        end
        S_RESP: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
        default: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_rdy    = (state_q == S_IDLE);
  assign bus.resp_vld   = (state_q == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_resp.sv
// Self-checking bench for mem_resp: directed table, corner sequences and
// randomized traffic against a transaction-level memory model.
module tb_mem_resp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Bench-side request drive, steered to one DUT by sel.
  bit          sel = 1'b0;
  logic        vld = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;

  mem_resp_if if4();
  mem_resp_if if1();
  logic busy4, busy1;

  assign if4.req_vld   = vld && !sel;
  assign if4.req_we    = we;
  assign if4.req_addr  = addr;
  assign if4.req_wdata = wdata;
  assign if1.req_vld   = vld && sel;
  assign if1.req_we    = we;
  assign if1.req_addr  = addr;
  assign if1.req_wdata = wdata;

  mem_resp #(.DEPTH_LOG2(12), .LATENCY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4), .busy(busy4));
  mem_resp #(.DEPTH_LOG2(12), .LATENCY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

  logic        s_rdy, s_vld, s_err, s_busy;
  logic [15:0] s_rd;
  always_comb begin
    s_rdy  = sel ? if1.req_rdy    : if4.req_rdy;
    s_vld  = sel ? if1.resp_vld   : if4.resp_vld;
    s_err  = sel ? if1.resp_err   : if4.resp_err;
    s_rd   = sel ? if1.resp_rdata : if4.resp_rdata;
    s_busy = sel ? busy1          : busy4;
  end

  // Reference memory: key = dut*65536 + addr; absent keys are unknown contents.
  logic [15:0] mdl [int];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One transaction: wait for ready, accept, time the response, check against the model.
  task automatic run(input bit we_i, input logic [15:0] a, input logic [15:0] wd,
                     input bit hold, output logic [15:0] rd, output logic er,
                     output longint acc);
    int  lat_exp;
    int  n;
    int  key;
    bit  inr;
    lat_exp = sel ? 1 : 4;
    rd = '0; er = 1'b0; acc = 0;
    @(negedge clk);
    we = we_i; addr = a; wdata = wd; vld = 1'b1;
    n = 0;
    while (!s_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_rdy) begin
      chk("accept_timeout", 32'(s_rdy), 32'd1);
      vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    if (!hold) vld = 1'b0;
    n = 0;
    while (!s_vld && n < 40) begin
      chk("rdy_low_in_wait", 32'(s_rdy), 32'd0);
      chk("busy_in_wait", 32'(s_busy), 32'd1);
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_vld) begin
      chk("resp_timeout", 32'(s_vld), 32'd1);
      vld = 1'b0;
      return;
    end
    chk("latency", 32'(n), 32'(lat_exp));
    chk("rdy_low_in_resp", 32'(s_rdy), 32'd0);
    chk("busy_in_resp", 32'(s_busy), 32'd1);
    rd = s_rd;
    er = s_err;
    @(posedge clk);
    #1;
    chk("resp_single_pulse", 32'(s_vld), 32'd0);
    chk("rdy_after_resp", 32'(s_rdy), 32'd1);

    inr = (a < 16'h1000);
    key = (sel ? 65536 : 0) + int'(a);
    chk("model_err", 32'(er), 32'(!inr));
    if (we_i) begin
      chk("model_wr_rdata", 32'(rd), 32'd0);
      if (inr) mdl[key] = wd;
    end else if (!inr) begin
      chk("model_oor_rdata", 32'(rd), 32'd0);
    end else if (mdl.exists(key)) begin
      chk("model_rd_rdata", 32'(rd), 32'(mdl[key]));
    end
  endtask

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  initial begin
    vec_t        tab [9];
    logic [15:0] rd;
    logic        er;
    longint      acc [3];
    longint      dummy;
    int          pulses;

    tab[0] = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
    tab[1] = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
    tab[2] = '{1'b1, 16'h0000, 16'h7777, 16'h0000, 1'b0};
    tab[3] = '{1'b1, 16'h1000, 16'h1234, 16'h0000, 1'b1};
    tab[4] = '{1'b0, 16'h0000, 16'h0000, 16'h7777, 1'b0};
    tab[5] = '{1'b0, 16'h1000, 16'h0000, 16'h0000, 1'b1};
    tab[6] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b1};
    tab[7] = '{1'b1, 16'h0FFF, 16'hC3C3, 16'h0000, 1'b0};
    tab[8] = '{1'b0, 16'h0FFF, 16'h0000, 16'hC3C3, 1'b0};

    // Reset state, both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rdy4", 32'(if4.req_rdy), 32'd1);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_vld4", 32'(if4.resp_vld), 32'd0);
    chk("rst_rdata4", 32'(if4.resp_rdata), 32'd0);
    chk("rst_err4", 32'(if4.resp_err), 32'd0);
    chk("rst_rdy1", 32'(if1.req_rdy), 32'd1);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_vld1", 32'(if1.resp_vld), 32'd0);

    // Directed table on the LATENCY=4 instance.
    sel = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run(tab[i].we, tab[i].addr, tab[i].wdata, 1'b0, rd, er, dummy);
      chk($sformatf("tab%0d_rdata", i), 32'(rd), 32'(tab[i].exp_rd));
      chk($sformatf("tab%0d_err", i), 32'(er), 32'(tab[i].exp_err));
    end

    // Back-to-back reads with req_vld held high.
    for (int i = 0; i < 3; i++) begin
      run(1'b0, 16'h0010, 16'h0000, (i < 2), rd, er, acc[i]);
      chk("b2b_rdata", 32'(rd), 32'hBEEF);
    end
    chk("b2b_gap01", 32'(acc[1] - acc[0]), 32'd6);
    chk("b2b_gap12", 32'(acc[2] - acc[1]), 32'd6);

    // Reset during WAIT of a write: no response, array keeps old data.
    run(1'b1, 16'h0020, 16'h5555, 1'b0, rd, er, dummy);
    @(negedge clk);
    chk("mid_rst_rdy_pre", 32'(s_rdy), 32'd1);
    we = 1'b1; addr = 16'h0020; wdata = 16'hAAAA; vld = 1'b1;
    @(posedge clk);
    #1;
    vld = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_busy_wait", 32'(s_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_async_busy", 32'(s_busy), 32'd0);
    chk("mid_rst_async_rdy", 32'(s_rdy), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (s_vld) pulses++;
    end
    chk("mid_rst_no_resp", 32'(pulses), 32'd0);
    run(1'b0, 16'h0020, 16'h0000, 1'b0, rd, er, dummy);
    chk("mid_rst_old_data", 32'(rd), 32'h5555);

    // LATENCY=1 instance: latency and 3-cycle accept spacing.
    sel = 1'b1;
    run(1'b1, 16'h0005, 16'h0ABC, 1'b0, rd, er, dummy);
    run(1'b0, 16'h0005, 16'h0000, 1'b1, rd, er, acc[0]);
    chk("l1_rdata0", 32'(rd), 32'h0ABC);
    run(1'b0, 16'h0005, 16'h0000, 1'b0, rd, er, acc[1]);
    chk("l1_rdata1", 32'(rd), 32'h0ABC);
    chk("l1_gap", 32'(acc[1] - acc[0]), 32'd3);

    // Randomized traffic against the model, both instances.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ra;
      sel = (i >= 40);
      ra = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
      run(1'($urandom_range(0, 1)), ra, 16'($urandom), 1'($urandom_range(0, 1)),
          rd, er, dummy);
    end
    vld = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_resp.md
# mem_resp

Multi-cycle memory responder serving the CPU's data-memory port over a valid/ready request and single-pulse response handshake. It models a word-addressed backing store with configurable fixed access latency. The CPU load/store path can therefore be built and verified against realistic stall behaviour instead of single-cycle memory. It sits between the CPU top and the backing storage array, owns the array, and returns read data or write acknowledgements.

## Interface
- `DEPTH_LOG2`, 12 — backing store holds 2^DEPTH_LOG2 16-bit words.
- `LATENCY`, 4 — number of cycles from request acceptance to response; legal range 1..15.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset. The already-decided requirement is: reset `rst_n`, asynchronous, active-low; clock `clk`.
- `req_vld` in 1 — request valid from CPU.
- `req_rdy` out 1 — responder can accept a request.
- `req_we` in 1 — 1 = write, 0 = read.
- `req_addr` in 16 — word address.
- `req_wdata` in 16 — write data.
- `resp_vld` out 1 — one-cycle response pulse.
- `resp_rdata` out 16 — read data; valid only while `resp_vld` is high.
- `resp_err` out 1 — address out of range; valid only while `resp_vld` is high.
- `busy` out 1 — a request is in flight, i.e. the block is in WAIT or RESP.

## Operation
- The FSM has three states: IDLE, WAIT, and RESP. `req_rdy` is 1 only in IDLE.
- **IDLE:** when `req_vld` and `req_rdy` are both high at an edge, the request is accepted.
  - Latch `req_we`, `req_addr`, and `req_wdata`.
  - Load the counter with LATENCY-1.
  - Go to WAIT.
- Inputs are ignored outside the accept edge. The CPU may change them freely afterwards.
- **WAIT:** at each edge, if the counter is 0, perform the access and go to RESP. Otherwise decrement the counter.
- **Access rules:**
  - Address in range means `addr < 2^DEPTH_LOG2`.
  - Read in range: `resp_rdata` = stored word, `resp_err` = 0.
  - Write in range: the array is updated and `resp_rdata` = 0x0000.
  - Out of range: there is no array write, `resp_rdata` = 0x0000, and `resp_err` = 1.
- **RESP:** `resp_vld` = 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. There is no response backpressure.
- Array contents are not reset and are undefined at power-up.
- A write is committed only at the WAIT-to-RESP edge.
- A read issued after a write's `resp_vld` to the same address returns the new data.

## Timing
- **Reset values:** state = IDLE, `req_rdy` = 1, `resp_vld` = 0, `resp_rdata` = 0x0000, `resp_err` = 0, `busy` = 0, counter = 0.
- Reset is asynchronous and takes effect mid-operation. An in-flight request is dropped with no response. A write that has not yet reached its commit edge does not modify the array.
- **Latency:** accept at edge E0; `resp_vld` is high during the cycle after edge E0+LATENCY.
  - LATENCY = 1: response in the cycle after E0+1.
- **Throughput:**
  - `req_rdy` returns high in the cycle after the `resp_vld` cycle.
  - The earliest next accept is edge E0+LATENCY+2, so one request per LATENCY+2 cycles.
- `req_vld` held high through RESP is accepted only at the next IDLE edge. It is never accepted during WAIT or RESP.
- All outputs are registered or decoded from state only. There are no combinational paths from the `req_*` inputs to any output.

## Structure
- **Shared package (`mem_pkg`):**
  - State encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - `ADDR_W` = 16 and `DATA_W` = 16.
  - Counter width = 4.
- **Sub-module `mem_array`:**
  - Parameter `DEPTH_LOG2`.
  - Synchronous write with enable.
  - Combinational read of a `DEPTH_LOG2`-bit index.
  - No reset.
- **`mem_resp` owns:** the FSM, the request latch, the counter, the range check, and the response registers.

## Test plan
- **Reset:** hold `rst_n` low, then release. Expect `req_rdy` = 1 and `busy` = 0, with `resp_vld` = 0 and `resp_rdata` = 0x0000 on the first cycle.
- **Write then read, LATENCY = 4:**
  - Write 0xBEEF to address 0x0010. Expect `resp_vld` 4 cycles after accept, with `resp_rdata` = 0 and `resp_err` = 0.
  - Read 0x0010. Expect `resp_rdata` = 0xBEEF, 4 cycles after accept.
- **Out of range, `DEPTH_LOG2` = 12:** write 0x1234 to 0x1000. Expect `resp_err` = 1. Then read address 0x0000 and confirm it is unchanged.
- **Back-to-back requests:** hold `req_vld` high continuously with 3 reads. Expect accepts exactly LATENCY+2 = 6 cycles apart, with `req_rdy` = 0 throughout WAIT and RESP.
- **Reset mid-operation:** assert `rst_n` during WAIT of a write of 0xAAAA to 0x0020, where 0x0020 previously held 0x5555.
  - Expect no `resp_vld` for the dropped request.
  - A subsequent read of 0x0020 returns 0x5555.
- **LATENCY = 1:** a read of a preloaded word returns `resp_vld` exactly 1 cycle after the accept edge, and the next accept happens 3 cycles after the first.
